// File: rtl/add_subt_arbiter_if.sv
// Handshake and datapath bundle shared by add_subt_arbiter and its environment.
// ADDSUB_ARB_ZERO_FLAG_EN adds the resp_zero_o response flag.
interface add_subt_arbiter_if #(
    parameter int SWR = 26
);
    logic           req0_valid_i;
    logic           req0_ready_o;
    logic           req0_op_i;
    logic [SWR-1:0] req0_a_i;
    logic [SWR-1:0] req0_b_i;
    logic           req1_valid_i;
    logic           req1_ready_o;
    logic           req1_op_i;
    logic [SWR-1:0] req1_a_i;
    logic [SWR-1:0] req1_b_i;
    logic           as_load_o;
    logic           as_op_o;
    logic [SWR-1:0] as_data_a_o;
    logic [SWR-1:0] as_data_b_o;
    logic [SWR-1:0] as_result_i;
    logic           as_carry_i;
    logic           resp_valid_o;
    logic           resp_ready_i;
    logic           resp_id_o;
    logic [SWR-1:0] resp_data_o;
    logic           resp_carry_o;
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
    logic           resp_zero_o;
`endif

    modport slave (
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        input  as_result_i, as_carry_i, resp_ready_i,
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
        output resp_zero_o,
`endif
        output req0_ready_o, req1_ready_o,
        output as_load_o, as_op_o, as_data_a_o, as_data_b_o,
        output resp_valid_o, resp_id_o, resp_data_o, resp_carry_o
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        output as_result_i, as_carry_i, resp_ready_i,
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
        input  resp_zero_o,
`endif
        input  req0_ready_o, req1_ready_o,
        input  as_load_o, as_op_o, as_data_a_o, as_data_b_o,
        input  resp_valid_o, resp_id_o, resp_data_o, resp_carry_o
    );
endinterface

// File: rtl/add_subt_arbiter.sv
// Round-robin sequencer sharing one registered add/subtract datapath between two requesters.
// Optional ADDSUB_ARB_ZERO_FLAG_EN registers a result-is-zero flag with the response.
module add_subt_arbiter #(
    parameter int SWR = 26
) (
    input logic                clk,
    input logic                rst,
    add_subt_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           op_q, op_d;
    logic [SWR-1:0] a_q, a_d;
    logic [SWR-1:0] b_q, b_d;
    logic           id_q, id_d;
    logic           load_q, load_d;
    logic           carry_q, carry_d;
    logic [SWR-1:0] data_q, data_d;
    logic           valid_q, valid_d;
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
    logic           zero_q, zero_d;
`endif

    logic grant_s;
    logic ready0_s;
    logic ready1_s;

    // Grant and combinational accept: contention goes to whoever was not served last.
    always_comb begin
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            grant_s = ~last_grant_q;
        end else begin
            grant_s = bus.req1_valid_i;
        end
        ready0_s = (state_q == IDLE) && bus.req0_valid_i && (grant_s == 1'b0);
        ready1_s = (state_q == IDLE) && bus.req1_valid_i && (grant_s == 1'b1);
    end

    // Next-state and next-register values for the sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        load_d       = 1'b0;
        carry_d      = carry_q;
        data_d       = data_q;
        valid_d      = valid_q;
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
        zero_d       = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (ready0_s || ready1_s) begin
                    op_d         = ready1_s ? bus.req1_op_i : bus.req0_op_i;
                    a_d          = ready1_s ? bus.req1_a_i  : bus.req0_a_i;
                    b_d          = ready1_s ? bus.req1_b_i  : bus.req0_b_i;
                    id_d         = ready1_s;
                    last_grant_d = ready1_s;
                    load_d       = 1'b1;
                    state_d      = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // Carry-out is combinational from the datapath, so it is only valid now.
                carry_d = bus.as_carry_i;
                state_d = CAPT;
            end
            CAPT: begin
                data_d  = bus.as_result_i;
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
                zero_d  = (bus.as_result_i == {SWR{1'b0}});
`endif
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            a_q          <= {SWR{1'b0}};
            b_q          <= {SWR{1'b0}};
            id_q         <= 1'b0;
            load_q       <= 1'b0;
            carry_q      <= 1'b0;
            data_q       <= {SWR{1'b0}};
            valid_q      <= 1'b0;
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
            zero_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            load_q       <= load_d;
            carry_q      <= carry_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
            zero_q       <= zero_d;
`endif
        end
    end

    assign bus.req0_ready_o = ready0_s;
    assign bus.req1_ready_o = ready1_s;
    assign bus.as_load_o    = load_q;
    assign bus.as_op_o      = op_q;
    assign bus.as_data_a_o  = a_q;
    assign bus.as_data_b_o  = b_q;
    assign bus.resp_valid_o = valid_q;
    assign bus.resp_id_o    = id_q;
    assign bus.resp_data_o  = data_q;
    assign bus.resp_carry_o = carry_q;
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
    assign bus.resp_zero_o  = zero_q;
`endif
endmodule

// File: tb/tb_add_subt_arbiter.sv
// Directed scoreboard bench for add_subt_arbiter with a behavioural shared adder.
module tb_add_subt_arbiter;
    localparam int SWR = 26;

    typedef struct packed {
        logic           id;
        logic [SWR-1:0] data;
        logic           carry;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    add_subt_arbiter_if #(.SWR(SWR)) bus ();

    add_subt_arbiter #(.SWR(SWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Shared datapath: combinational carry, registered result.
    logic [SWR:0]   dp_sum;
    logic [SWR-1:0] dp_result = '0;
    assign dp_sum = {1'b0, bus.as_data_a_o}
                  + {1'b0, (bus.as_op_o ? ~bus.as_data_b_o : bus.as_data_b_o)}
                  + {{SWR{1'b0}}, bus.as_op_o};
    assign bus.as_carry_i  = dp_sum[SWR];
    assign bus.as_result_i = dp_result;
    always @(posedge clk) if (bus.as_load_o) dp_result <= dp_sum[SWR-1:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic op,
                                   input logic [SWR-1:0] a, input logic [SWR-1:0] b);
        exp_t        e;
        logic [SWR:0] s;
        e.id = id;
        if (op) begin
            e.data  = a - b;
            e.carry = (a >= b);
        end else begin
            s       = {1'b0, a} + {1'b0, b};
            e.data  = s[SWR-1:0];
            e.carry = s[SWR];
        end
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_id"},    {31'd0, bus.resp_id_o},    {31'd0, e.id});
            chk({tag, "_data"},  {6'd0, bus.resp_data_o},   {6'd0, e.data});
            chk({tag, "_carry"}, {31'd0, bus.resp_carry_o}, {31'd0, e.carry});
`ifdef ADDSUB_ARB_ZERO_FLAG_EN
            chk({tag, "_zero"},  {31'd0, bus.resp_zero_o},  {31'd0, (e.data == {SWR{1'b0}})});
`endif
        end
    endtask

    task automatic drive_req(input logic id, input logic v, input logic op,
                             input logic [SWR-1:0] a, input logic [SWR-1:0] b);
        if (id) begin
            bus.req1_valid_i = v; bus.req1_op_i = op; bus.req1_a_i = a; bus.req1_b_i = b;
        end else begin
            bus.req0_valid_i = v; bus.req0_op_i = op; bus.req0_a_i = a; bus.req0_b_i = b;
        end
    endtask

    // One operation through all four states; hold > 0 stalls the response that many cycles.
    task automatic do_op(input string tag, input logic id, input logic op,
                         input logic [SWR-1:0] a, input logic [SWR-1:0] b, input int hold);
        int   n;
        exp_t e;
        logic rdy;
        @(negedge clk);
        bus.resp_ready_i = (hold == 0);
        drive_req(id, 1'b1, op, a, b);
        #1;
        n = 0;
        rdy = id ? bus.req1_ready_o : bus.req0_ready_o;
        while (!rdy && n < 8) begin
            @(negedge clk); #1; n++;
            rdy = id ? bus.req1_ready_o : bus.req0_ready_o;
        end
        chk({tag, "_accept"}, {31'd0, rdy}, 32'd1);
        sb.push_back(model(id, op, a, b));
        @(negedge clk);
        drive_req(id, 1'b0, 1'b0, '0, '0);
        #1;
        chk({tag, "_load_c1"}, {31'd0, bus.as_load_o}, 32'd1);
        chk({tag, "_op_c1"},   {31'd0, bus.as_op_o},   {31'd0, op});
        chk({tag, "_a_c1"},    {6'd0, bus.as_data_a_o}, {6'd0, a});
        chk({tag, "_b_c1"},    {6'd0, bus.as_data_b_o}, {6'd0, b});
        @(negedge clk); #1;
        chk({tag, "_load_c2"},  {31'd0, bus.as_load_o},    32'd0);
        chk({tag, "_valid_c2"}, {31'd0, bus.resp_valid_o}, 32'd0);
        @(negedge clk); #1;
        chk({tag, "_valid_c3"}, {31'd0, bus.resp_valid_o}, 32'd1);
        e = model(id, op, a, b);
        pop_check(tag);
        if (hold > 0) begin
            drive_req(1'b0, 1'b1, 1'b0, '0, '0);
            drive_req(1'b1, 1'b1, 1'b0, '0, '0);
            for (int k = 1; k < hold; k++) begin
                @(negedge clk); #1;
                chk({tag, "_bp_valid"}, {31'd0, bus.resp_valid_o}, 32'd1);
                chk({tag, "_bp_data"},  {6'd0, bus.resp_data_o},   {6'd0, e.data});
                chk({tag, "_bp_id"},    {31'd0, bus.resp_id_o},    {31'd0, e.id});
                chk({tag, "_bp_carry"}, {31'd0, bus.resp_carry_o}, {31'd0, e.carry});
                chk({tag, "_bp_rdy"},   {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
                chk({tag, "_bp_load"},  {31'd0, bus.as_load_o},    32'd0);
            end
            @(negedge clk);
            bus.resp_ready_i = 1'b1;
            #1;
            chk({tag, "_rel_valid"}, {31'd0, bus.resp_valid_o}, 32'd1);
            chk({tag, "_rel_rdy"},   {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
            @(negedge clk); #1;
            chk({tag, "_idle_valid"}, {31'd0, bus.resp_valid_o}, 32'd0);
            chk({tag, "_idle_rdy"},   {30'd0, bus.req1_ready_o, bus.req0_ready_o},
                id ? 32'd1 : 32'd2);
            drive_req(1'b0, 1'b0, 1'b0, '0, '0);
            drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        end
    endtask

    initial begin
        int   seen;
        int   nacc;
        logic g[$];
        int   gc[$];

        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        bus.resp_ready_i = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid",  {31'd0, bus.resp_valid_o}, 32'd0);
        chk("rst_load",   {31'd0, bus.as_load_o},    32'd0);
        chk("rst_a",      {6'd0, bus.as_data_a_o},   32'd0);
        chk("rst_data",   {6'd0, bus.resp_data_o},   32'd0);
        chk("rst_carry",  {31'd0, bus.resp_carry_o}, 32'd0);
        rst = 1'b1;

        do_op("add0",   1'b0, 1'b0, 26'h0000005, 26'h0000003, 0);
        do_op("sub1a",  1'b1, 1'b1, 26'h0000005, 26'h0000003, 0);
        do_op("sub1b",  1'b1, 1'b1, 26'h0000003, 26'h0000005, 0);
        do_op("addovf", 1'b0, 1'b0, 26'h3FFFFFF, 26'h0000002, 0);
        do_op("subeq",  1'b0, 1'b1, 26'h1234567, 26'h1234567, 0);
        do_op("bp",     1'b1, 1'b1, 26'h0000005, 26'h0000003, 5);

        // Reset during ISSUE: the op vanishes and last_grant returns to 1.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 26'h0000011, 26'h0000022);
        #1;
        chk("mid_accept", {31'd0, bus.req0_ready_o}, 32'd1);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("mid_issue_load", {31'd0, bus.as_load_o}, 32'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("mid_rst_load",  {31'd0, bus.as_load_o},    32'd0);
        chk("mid_rst_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (bus.resp_valid_o) seen++;
        end
        chk("mid_no_resp", seen, 32'd0);

        // Continuous contention: alternating grants every 4 cycles, req0 first.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 26'h000000A, 26'h0000014);
        drive_req(1'b1, 1'b1, 1'b1, 26'h0000007, 26'h0000009);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (bus.resp_valid_o) pop_check("cont");
            chk("cont_onehot", {31'd0, bus.req0_ready_o & bus.req1_ready_o}, 32'd0);
            if (bus.req0_ready_o || bus.req1_ready_o) begin
                g.push_back(bus.req1_ready_o);
                gc.push_back(i);
                if (bus.req1_ready_o) sb.push_back(model(1'b1, 1'b1, 26'h0000007, 26'h0000009));
                else                  sb.push_back(model(1'b0, 1'b0, 26'h000000A, 26'h0000014));
            end
        end
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        nacc = g.size();
        chk("cont_count", nacc, 32'd4);
        for (int i = 0; i < nacc && i < 4; i++) begin
            chk("cont_grant", {31'd0, g[i]}, {31'd0, (i % 2 == 1)});
            chk("cont_cycle", gc[i], i * 4);
        end
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
